// File: rtl/dco_ctrl_encoder.sv
// DCO control encoder: saturates the loop-filter word to an unsigned code, then drives
// a coarse thermometer bank and a sigma-delta dithered, DWA-rotated fine bank.
module dco_ctrl_encoder #(
  parameter int DCTRL_W     = 32,
  parameter int COARSE_BITS = 5,
  parameter int FINE_BITS   = 6,
  parameter int FRAC_BITS   = 6,
  localparam int CODE_W     = COARSE_BITS + FINE_BITS + FRAC_BITS,
  localparam int N_COARSE   = 2**COARSE_BITS - 1,
  localparam int N_FINE     = 2**FINE_BITS
) (
  input  logic                      refclk,
  input  logic                      reset,
  input  logic signed [DCTRL_W-1:0] dctrl,
  input  logic                      dctrl_valid,
  input  logic                      freeze,
  input  logic                      dem_en,
  output logic [N_COARSE-1:0]       coarse_therm,
  output logic [N_FINE-1:0]         fine_cells,
  output logic [FINE_BITS:0]        fine_count,
  output logic [CODE_W-1:0]         code_q,
  output logic                      sat_hi,
  output logic                      sat_lo
);

  localparam logic [CODE_W-1:0] MID = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic signed [DCTRL_W:0] MID_S =
    {{(DCTRL_W-CODE_W+1){1'b0}}, 1'b1, {(CODE_W-1){1'b0}}};
  localparam logic signed [DCTRL_W:0] CODE_MAX_S =
    {{(DCTRL_W-CODE_W+1){1'b0}}, {CODE_W{1'b1}}};

  logic signed [DCTRL_W:0]  u_wide;
  logic                     u_hi, u_lo, load;
  logic [CODE_W-1:0]        u_clamp, next_code;
  logic                     next_hi, next_lo;
  logic [COARSE_BITS-1:0]   coarse;
  logic [FINE_BITS-1:0]     fine;
  logic [FRAC_BITS-1:0]     frac, acc;
  logic [FRAC_BITS:0]       s;
  logic [FINE_BITS:0]       fine_total;
  logic [FINE_BITS-1:0]     ptr, ptr_eff, ptr_next;
  logic [N_COARSE-1:0]      therm_next, therm_rst;
  logic [N_FINE-1:0]        cells_next;

  // One extra bit of headroom keeps the offset sum from wrapping at either rail.
  assign u_wide  = $signed({dctrl[DCTRL_W-1], dctrl}) + MID_S;
  assign u_lo    = u_wide[DCTRL_W];
  assign u_hi    = u_wide > CODE_MAX_S;
  assign u_clamp = u_hi ? {CODE_W{1'b1}} : (u_lo ? '0 : u_wide[CODE_W-1:0]);

  assign load      = dctrl_valid && !freeze;
  assign next_code = load ? u_clamp : code_q;
  assign next_hi   = load ? u_hi : sat_hi;
  assign next_lo   = load ? u_lo : sat_lo;

  assign coarse = next_code[CODE_W-1 -: COARSE_BITS];
  assign fine   = next_code[FRAC_BITS +: FINE_BITS];
  assign frac   = next_code[FRAC_BITS-1:0];

  assign s          = {1'b0, acc} + {1'b0, frac};
  assign fine_total = {1'b0, fine} + {{FINE_BITS{1'b0}}, s[FRAC_BITS]};

  // A full-bank total advances the pointer by exactly one lap, i.e. not at all.
  assign ptr_eff  = dem_en ? ptr : '0;
  assign ptr_next = dem_en ? ptr + fine_total[FINE_BITS-1:0] : '0;

  for (genvar i = 0; i < N_COARSE; i++) begin : g_coarse
    localparam logic [COARSE_BITS-1:0] IDX = COARSE_BITS'(i);
    assign therm_next[i] = IDX < coarse;
    assign therm_rst[i]  = (i < 2**(COARSE_BITS-1));
  end

  for (genvar k = 0; k < N_FINE; k++) begin : g_fine
    localparam logic [FINE_BITS-1:0] IDX = FINE_BITS'(k);
    logic [FINE_BITS-1:0] off;
    assign off           = IDX - ptr_eff;
    assign cells_next[k] = {1'b0, off} < fine_total;
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      code_q       <= MID;
      sat_hi       <= 1'b0;
      sat_lo       <= 1'b0;
      acc          <= '0;
      ptr          <= '0;
      coarse_therm <= therm_rst;
      fine_cells   <= '0;
      fine_count   <= '0;
    end else if (!freeze) begin
      code_q       <= next_code;
      sat_hi       <= next_hi;
      sat_lo       <= next_lo;
      acc          <= s[FRAC_BITS-1:0];
      ptr          <= ptr_next;
      coarse_therm <= therm_next;
      fine_cells   <= cells_next;
      fine_count   <= fine_total;
    end
  end

endmodule
